// File: rtl/midi_pkg.sv
// midi_pkg: parser states, MIDI status nibbles and byte-class thresholds
package midi_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_D1, WAIT_D2} state_t;
  localparam logic [3:0] NOTE_OFF = 4'h8;
  localparam logic [3:0] NOTE_ON  = 4'h9;
  localparam logic [3:0] POLY_AT  = 4'hA;
  localparam logic [3:0] CC       = 4'hB;
  localparam logic [3:0] PROG     = 4'hC;
  localparam logic [3:0] CHAN_AT  = 4'hD;
  localparam logic [3:0] PITCH    = 4'hE;
  localparam logic [7:0] RT_MIN   = 8'hF8;
  localparam logic [7:0] SYS_MIN  = 8'hF0;
  function automatic logic two_data(input logic [3:0] hi);
    return hi inside {NOTE_OFF, NOTE_ON, POLY_AT, CC, PITCH};
  endfunction
endpackage

// File: rtl/midi_timeout_ctr.sv
// midi_timeout_ctr: saturating counter; clr zeroes, en counts up to TERM, tc flags TERM while enabled
module midi_timeout_ctr #(
  parameter int TERM = 31999
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);
  localparam int W = TERM > 0 ? $clog2(TERM + 1) : 1;
  localparam logic [W-1:0] LAST = W'(TERM);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? '0 : (en && cnt != LAST) ? cnt + 1'b1 : cnt;
  assign tc = en && cnt == LAST;
endmodule

// File: rtl/midi_rx_parser.sv
// midi_rx_parser: UART byte stream -> note-on/note-off/CC strobes with running status, channel filter, timeout
module midi_rx_parser #(
  parameter int CLKS_PER_BIT = 800,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_RX_DV,
  input  logic [7:0] i_RX_Byte,
  input  logic [3:0] i_Channel,
  input  logic       i_Omni,
  output logic       o_Note_On_DV,
  output logic       o_Note_Off_DV,
  output logic       o_CC_DV,
  output logic [6:0] o_Data1,
  output logic [6:0] o_Data2,
  output logic       o_Err,
  output logic       o_Running
);
  import midi_pkg::*;
  state_t state, state_nx;
  logic [7:0] status, status_nx;
  logic [6:0] d1, d1_nx;
  logic [3:0] hi;
  logic is_rt, is_sys, is_chs, is_dat, tc;
  logic complete, match, vel0, on_nx, off_nx, cc_nx, err_nx;
  assign hi     = status[7:4];
  assign is_rt  = i_RX_DV && i_RX_Byte >= RT_MIN;
  assign is_sys = i_RX_DV && i_RX_Byte >= SYS_MIN && i_RX_Byte < RT_MIN;
  assign is_chs = i_RX_DV && i_RX_Byte[7] && i_RX_Byte < SYS_MIN;
  assign is_dat = i_RX_DV && !i_RX_Byte[7];
  midi_timeout_ctr #(.TERM(CLKS_PER_BIT * TIMEOUT_BITS - 1)) u_tmo (
    .clk(i_Clk),
    .rst(i_Rst),
    .clr(i_RX_DV && !is_rt),
    .en (state == WAIT_D2),
    .tc (tc)
  );
  always_ff @(posedge i_Clk)
    if (i_Rst) begin
      state         <= IDLE;
      status        <= '0;
      d1            <= '0;
      o_Note_On_DV  <= 1'b0;
      o_Note_Off_DV <= 1'b0;
      o_CC_DV       <= 1'b0;
      o_Err         <= 1'b0;
      o_Data1       <= '0;
      o_Data2       <= '0;
    end else begin
      state         <= state_nx;
      status        <= status_nx;
      d1            <= d1_nx;
      o_Note_On_DV  <= on_nx;
      o_Note_Off_DV <= off_nx;
      o_CC_DV       <= cc_nx;
      o_Err         <= err_nx;
      if (on_nx || off_nx || cc_nx) begin
        o_Data1 <= d1;
        o_Data2 <= i_RX_Byte[6:0];
      end
    end
  // a data byte completing the message outranks a coincident timeout
  always_comb begin
    state_nx  = state;
    status_nx = status;
    d1_nx     = d1;
    if (is_chs) begin
      state_nx  = WAIT_D1;
      status_nx = i_RX_Byte;
    end else if (is_sys) begin
      state_nx  = IDLE;
      status_nx = '0;
    end else if (is_dat && state == WAIT_D1 && two_data(hi)) begin
      state_nx = WAIT_D2;
      d1_nx    = i_RX_Byte[6:0];
    end else if (state == WAIT_D2 && (is_dat || tc))
      state_nx = WAIT_D1;
  end
  always_comb begin
    complete = is_dat && state == WAIT_D2;
    match    = i_Omni || status[3:0] == i_Channel;
    vel0     = i_RX_Byte[6:0] == 7'd0;
    on_nx    = complete && match && hi == NOTE_ON && !vel0;
    off_nx   = complete && match && (hi == NOTE_OFF || (hi == NOTE_ON && vel0));
    cc_nx    = complete && match && hi == CC;
    err_nx   = state == WAIT_D2 && (is_chs || is_sys || (tc && !is_dat));
  end
  assign o_Running = state != IDLE;
endmodule

// File: tb/tb_midi_rx_parser.sv
// tb_midi_rx_parser: scoreboard bench for midi_rx_parser with a short timeout
module tb_midi_rx_parser;
  localparam int CPB = 8;
  localparam int TBITS = 40;
  localparam int TO = CPB * TBITS;
  localparam logic [1:0] K_ON = 2'd0, K_OFF = 2'd1, K_CC = 2'd2, K_ERR = 2'd3;
  typedef struct {
    logic [1:0] k;
    logic [6:0] a;
    logic [6:0] b;
    int         due;
  } ev_t;
  logic       i_Clk = 1'b0;
  logic       i_Rst = 1'b1;
  logic       i_RX_DV = 1'b0;
  logic [7:0] i_RX_Byte = '0;
  logic [3:0] i_Channel = '0;
  logic       i_Omni = 1'b0;
  logic       o_Note_On_DV, o_Note_Off_DV, o_CC_DV, o_Err, o_Running;
  logic [6:0] o_Data1, o_Data2;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  ev_t exp_q[$];
  ev_t me;
  logic [1:0] mk;
  midi_rx_parser #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(TBITS)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .i_RX_DV(i_RX_DV), .i_RX_Byte(i_RX_Byte),
    .i_Channel(i_Channel), .i_Omni(i_Omni), .o_Note_On_DV(o_Note_On_DV),
    .o_Note_Off_DV(o_Note_Off_DV), .o_CC_DV(o_CC_DV), .o_Data1(o_Data1),
    .o_Data2(o_Data2), .o_Err(o_Err), .o_Running(o_Running)
  );
  always #5 i_Clk = ~i_Clk;
  always @(posedge i_Clk) cyc <= cyc + 1;
  always @(negedge i_Clk) begin
    if (o_Err) begin
      n_cmp++;
      if (exp_q.size() == 0 || exp_q[0].k != K_ERR || exp_q[0].due != cyc) begin
        n_bad++;
        $display("FAIL err_event: got o_Err at cycle %0d, expected next event kind=%0d due=%0d (queue %0d)",
                 cyc, exp_q.size() ? exp_q[0].k : 2'd0, exp_q.size() ? exp_q[0].due : -1, exp_q.size());
      end
      if (exp_q.size() != 0 && exp_q[0].k == K_ERR) void'(exp_q.pop_front());
    end
    if (o_Note_On_DV || o_Note_Off_DV || o_CC_DV) begin
      n_cmp++;
      if (int'(o_Note_On_DV) + int'(o_Note_Off_DV) + int'(o_CC_DV) != 1) begin
        n_bad++;
        $display("FAIL strobe_onehot: got on/off/cc=%b%b%b, required exactly one", o_Note_On_DV, o_Note_Off_DV, o_CC_DV);
      end
      mk = o_Note_On_DV ? K_ON : o_Note_Off_DV ? K_OFF : K_CC;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_strobe: got kind=%0d d1=%h d2=%h at cycle %0d, required none", mk, o_Data1, o_Data2, cyc);
      end else begin
        me = exp_q.pop_front();
        if (me.k !== mk || me.a !== o_Data1 || me.b !== o_Data2 || me.due != cyc) begin
          n_bad++;
          $display("FAIL strobe_event: got kind=%0d d1=%h d2=%h cyc=%0d, required kind=%0d d1=%h d2=%h cyc=%0d",
                   mk, o_Data1, o_Data2, cyc, me.k, me.a, me.b, me.due);
        end
      end
    end
  end
  task automatic send(input logic [7:0] b);
    i_RX_DV = 1'b1;
    i_RX_Byte = b;
    @(negedge i_Clk);
    i_RX_DV = 1'b0;
  endtask
  task automatic push(input logic [1:0] k, input logic [6:0] a, input logic [6:0] b, input int due);
    exp_q.push_back('{k: k, a: a, b: b, due: due});
  endtask
  task automatic drain(input string name);
    for (int i = 0; i < TO + 20 && exp_q.size() != 0; i++) @(negedge i_Clk);
    repeat (3) @(negedge i_Clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL %s_drain: got %0d events still pending, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic test_reset;
    i_Rst = 1'b1;
    repeat (3) @(negedge i_Clk);
    n_cmp++;
    if ({o_Note_On_DV, o_Note_Off_DV, o_CC_DV, o_Err, o_Running} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b, required 00000", {o_Note_On_DV, o_Note_Off_DV, o_CC_DV, o_Err, o_Running});
    end
    n_cmp++;
    if (o_Data1 !== 7'h00 || o_Data2 !== 7'h00) begin
      n_bad++;
      $display("FAIL reset_data: got %h/%h, required 00/00", o_Data1, o_Data2);
    end
    i_Rst = 1'b0;
    @(negedge i_Clk);
  endtask
  task automatic test_note_on;
    send(8'h90);
    send(8'h3C);
    push(K_ON, 7'h3C, 7'h64, cyc + 1);
    send(8'h64);
    drain("note_on");
    n_cmp++;
    if (o_Running !== 1'b1) begin
      n_bad++;
      $display("FAIL note_on_running: got %b, required 1", o_Running);
    end
  endtask
  task automatic test_running_status;
    send(8'h90);
    send(8'h40);
    push(K_ON, 7'h40, 7'h50, cyc + 1);
    send(8'h50);
    send(8'h40);
    push(K_OFF, 7'h40, 7'h00, cyc + 1);
    send(8'h00);
    drain("running");
  endtask
  task automatic test_channel_filter;
    send(8'h92);
    send(8'h3C);
    send(8'h64);
    drain("filter_off");
    n_cmp++;
    if (o_Data1 !== 7'h40 || o_Data2 !== 7'h00) begin
      n_bad++;
      $display("FAIL filter_data_held: got %h/%h, required 40/00", o_Data1, o_Data2);
    end
    i_Omni = 1'b1;
    send(8'h92);
    send(8'h3C);
    push(K_ON, 7'h3C, 7'h64, cyc + 1);
    send(8'h64);
    drain("filter_omni");
    i_Omni = 1'b0;
    send(8'h93);
    send(8'h10);
    i_Channel = 4'd3;
    push(K_ON, 7'h10, 7'h20, cyc + 1);
    send(8'h20);
    drain("filter_late_channel");
    i_Channel = 4'd0;
  endtask
  task automatic test_realtime;
    send(8'hB0);
    send(8'hF8);
    send(8'h07);
    send(8'hFE);
    push(K_CC, 7'h07, 7'h7F, cyc + 1);
    send(8'h7F);
    drain("realtime");
  endtask
  task automatic test_other_status;
    send(8'h80);
    send(8'h3C);
    push(K_OFF, 7'h3C, 7'h40, cyc + 1);
    send(8'h40);
    send(8'hC0);
    send(8'h05);
    send(8'h06);
    send(8'hE0);
    send(8'h01);
    send(8'h02);
    send(8'hA0);
    send(8'h11);
    send(8'h22);
    drain("other_status");
    n_cmp++;
    if (o_Data1 !== 7'h3C || o_Data2 !== 7'h40) begin
      n_bad++;
      $display("FAIL silent_data_held: got %h/%h, required 3C/40", o_Data1, o_Data2);
    end
  endtask
  task automatic test_timeout;
    send(8'h90);
    push(K_ERR, 7'h00, 7'h00, cyc + TO + 1);
    send(8'h3C);
    repeat (TO + 5) @(negedge i_Clk);
    drain("timeout");
    n_cmp++;
    if (o_Running !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout_running: got %b, required 1", o_Running);
    end
    send(8'h45);
    push(K_ON, 7'h45, 7'h20, cyc + 1);
    send(8'h20);
    drain("timeout_resume");
  endtask
  task automatic test_timeout_race;
    send(8'h90);
    send(8'h3C);
    repeat (TO - 1) @(negedge i_Clk);
    push(K_ON, 7'h3C, 7'h11, cyc + 1);
    send(8'h11);
    drain("timeout_race");
  endtask
  task automatic test_sysex;
    send(8'h90);
    send(8'h3C);
    push(K_ERR, 7'h00, 7'h00, cyc + 1);
    send(8'hF0);
    send(8'h01);
    send(8'h02);
    send(8'hF7);
    send(8'h3C);
    send(8'h10);
    drain("sysex");
    n_cmp++;
    if (o_Running !== 1'b0) begin
      n_bad++;
      $display("FAIL sysex_running: got %b, required 0", o_Running);
    end
  endtask
  task automatic test_reset_mid;
    send(8'h80);
    send(8'h3C);
    i_Rst = 1'b1;
    @(negedge i_Clk);
    i_Rst = 1'b0;
    n_cmp++;
    if ({o_Note_On_DV, o_Note_Off_DV, o_CC_DV, o_Err, o_Running} !== 5'b0 || o_Data1 !== 7'h00 || o_Data2 !== 7'h00) begin
      n_bad++;
      $display("FAIL reset_mid: got flags=%b data=%h/%h, required 00000 00/00",
               {o_Note_On_DV, o_Note_Off_DV, o_CC_DV, o_Err, o_Running}, o_Data1, o_Data2);
    end
    send(8'h40);
    send(8'h3C);
    send(8'h40);
    drain("reset_mid");
  endtask
  initial begin
    @(negedge i_Clk);
    test_reset;
    test_note_on;
    test_running_status;
    test_channel_filter;
    test_realtime;
    test_other_status;
    test_timeout;
    test_timeout_race;
    test_sysex;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
